mandelbrot_lanes: RTL

MANDELBROT_LANES -- requirements
Module: mandelbrot_lanes

---
 rtl/mandelbrot_pkg.sv | 19 +
 rtl/mandelbrot_alu.sv | 35 +++
 rtl/mandelbrot_lane.sv | 87 ++++++++
 rtl/mandelbrot_lanes.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the multi-lane Mandelbrot/Julia renderer.
package mandelbrot_pkg;

    typedef enum logic [1:0] {
        LaneIdle = 2'd0,
        LaneIter = 2'd1,
        LaneDone = 2'd2
    } lane_state_t;

    localparam int unsigned DefaultWidth  = 640;
    localparam int unsigned DefaultHeight = 480;
    localparam int unsigned DefaultLanes  = 4;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mandelbrot_alu.sv
// One complex iteration step z' = z^2 + c in signed fixed point with WIDTH-4 fraction bits.
// size flags |z|^2 >= 4 on the incoming z.
module mandelbrot_alu #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] in_cr,
    input  logic [WIDTH-1:0] in_ci,
    input  logic [WIDTH-1:0] in_zr,
    input  logic [WIDTH-1:0] in_zi,
    output logic [WIDTH-1:0] out_zr,
    output logic [WIDTH-1:0] out_zi,
    output logic             size
);

    localparam int Frac = WIDTH - 4;
    localparam int Pw   = 2 * WIDTH + 1;
    localparam logic signed [Pw-1:0] Limit = Pw'(4) <<< (2 * Frac);

    logic signed [Pw-1:0] zr, zi, zr2, zi2, zrzi, re, im;

    // Full-precision products, rescaled and wrapped back to WIDTH bits.
    always_comb begin
        zr     = Pw'($signed(in_zr));
        zi     = Pw'($signed(in_zi));
        zr2    = zr * zr;
        zi2    = zi * zi;
        zrzi   = zr * zi;
        re     = (zr2 - zi2) >>> Frac;
        im     = (zrzi <<< 1) >>> Frac;
        out_zr = re[WIDTH-1:0] + in_cr;
        out_zi = im[WIDTH-1:0] + in_ci;
        size   = (zr2 + zi2) >= Limit;
    end

endmodule

// File: rtl/mandelbrot_lane.sv
// One iteration lane: IDLE -> ITER (on load) -> DONE (escape or max_ctr) -> IDLE (on free).
module mandelbrot_lane
    import mandelbrot_pkg::*;
#(
    parameter int BITWIDTH = 10,
    parameter int CTRWIDTH = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [BITWIDTH-1:0] load_cr,
    input  logic [BITWIDTH-1:0] load_ci,
    input  logic [BITWIDTH-1:0] load_zr,
    input  logic [BITWIDTH-1:0] load_zi,
    input  logic [CTRWIDTH-1:0] max_ctr,
    input  logic                free,
    output logic [1:0]          state,
    output logic [CTRWIDTH-1:0] ctr
);

    lane_state_t         state_q, state_d;
    logic [BITWIDTH-1:0] cr_q, ci_q, zr_q, zi_q;
    logic [BITWIDTH-1:0] alu_zr, alu_zi;
    logic [CTRWIDTH-1:0] ctr_q;
    logic                alu_size, stop, step_en;

    mandelbrot_alu #(.WIDTH(BITWIDTH)) u_alu (
        .in_cr  (cr_q),
        .in_ci  (ci_q),
        .in_zr  (zr_q),
        .in_zi  (zi_q),
        .out_zr (alu_zr),
        .out_zi (alu_zi),
        .size   (alu_size)
    );

    assign stop = alu_size || (ctr_q == max_ctr);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= LaneIdle;
        else       state_q <= state_d;
    end

    // Next state; a load wins so a lane freed this cycle can be refilled at once.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = LaneIter;
        end else begin
            unique case (state_q)
                LaneIter: if (stop) state_d = LaneDone;
                LaneDone: if (free) state_d = LaneIdle;
                default:  state_d = state_q;
            endcase
        end
    end

    // Outputs and iteration enable.
    always_comb begin
        step_en = (state_q == LaneIter) && !stop && !load;
        state   = state_q;
        ctr     = ctr_q;
    end

    // Pixel datapath: load c/z, then iterate until stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            cr_q  <= '0;
            ci_q  <= '0;
            zr_q  <= '0;
            zi_q  <= '0;
            ctr_q <= '0;
        end else if (load) begin
            cr_q  <= load_cr;
            ci_q  <= load_ci;
            zr_q  <= load_zr;
            zi_q  <= load_zi;
            ctr_q <= '0;
        end else if (step_en) begin
            zr_q  <= alu_zr;
            zi_q  <= alu_zi;
            ctr_q <= ctr_q + 1'b1;
        end
    end

endmodule

// File: rtl/mandelbrot_lanes.sv
// Multi-lane fractal frame renderer: dispatches pixels in raster order round-robin to LANES
// lanes and returns results in the same order through a valid/ready port.
// Optional Julia mode is built when MANDELBROT_JULIA_EN is defined.
module mandelbrot_lanes
    import mandelbrot_pkg::*;
#(
    parameter int BITWIDTH = 10,
    parameter int CTRWIDTH = 7,
    parameter int LANES    = DefaultLanes,
    parameter int WIDTH    = DefaultWidth,
    parameter int HEIGHT   = DefaultHeight
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                running,
    input  logic [BITWIDTH-1:0] cr_start,
    input  logic [BITWIDTH-1:0] ci_start,
    input  logic [BITWIDTH-1:0] step,
    input  logic [CTRWIDTH-1:0] max_ctr,
    input  logic [2:0]          ctr_select,
`ifdef MANDELBROT_JULIA_EN
    input  logic                julia,
    input  logic [BITWIDTH-1:0] jcr,
    input  logic [BITWIDTH-1:0] jci,
`endif
    output logic [3:0]          ctr_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    localparam int PtrW = ptr_width(LANES);
    localparam int XW   = ptr_width(WIDTH);
    localparam int YW   = ptr_width(HEIGHT);
    localparam int NW   = ptr_width(WIDTH * HEIGHT);

    logic                running_q, disp_done_q;
    logic [BITWIDTH-1:0] cr_start_q, step_q, cr_q, ci_q;
    logic [CTRWIDTH-1:0] max_ctr_q;
    logic [2:0]          ctr_select_q;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [NW-1:0]       out_cnt_q;
    logic [PtrW-1:0]     dispatch_ptr_q, out_ptr_q;
`ifdef MANDELBROT_JULIA_EN
    logic                julia_q;
    logic [BITWIDTH-1:0] jcr_q, jci_q;
`endif

    logic [1:0]          lane_state [LANES];
    logic [CTRWIDTH-1:0] lane_ctr   [LANES];
    logic [LANES-1:0]    lane_load, lane_free;
    logic [BITWIDTH-1:0] ld_cr, ld_ci, ld_zr, ld_zi;
    logic [CTRWIDTH+3:0] ctr_shift;
    logic                accept, xfer, dispatch, last_pixel;

    // Handshake, dispatch decision and per-lane load/free strobes.
    always_comb begin
        accept     = run && !running_q;
        out_valid  = lane_state[out_ptr_q] == LaneDone;
        xfer       = out_valid && out_ready;
        out_last   = out_valid && (out_cnt_q == NW'(WIDTH * HEIGHT - 1));
        // The lane being drained this cycle counts as free for the dispatcher.
        dispatch   = running_q && !disp_done_q &&
                     ((lane_state[dispatch_ptr_q] == LaneIdle) ||
                      (xfer && (dispatch_ptr_q == out_ptr_q)));
        last_pixel = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));
        ctr_shift  = {4'b0000, lane_ctr[out_ptr_q]} >> ctr_select_q;
        ctr_out    = ctr_shift[3:0];
        running    = running_q;
        for (int i = 0; i < LANES; i++) begin
            lane_load[i] = dispatch && (dispatch_ptr_q == PtrW'(i));
            lane_free[i] = xfer && (out_ptr_q == PtrW'(i));
        end
    end

    // Initial c and z for the pixel being dispatched.
    always_comb begin
`ifdef MANDELBROT_JULIA_EN
        if (julia_q) begin
            ld_cr = jcr_q;
            ld_ci = jci_q;
            ld_zr = cr_q;
            ld_zi = ci_q;
        end else begin
            ld_cr = cr_q;
            ld_ci = ci_q;
            ld_zr = '0;
            ld_zi = '0;
        end
`else
        ld_cr = cr_q;
        ld_ci = ci_q;
        ld_zr = '0;
        ld_zi = '0;
`endif
    end

    // Frame control: config latch, raster walk and both ring pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_q      <= 1'b0;
            disp_done_q    <= 1'b0;
            cr_start_q     <= '0;
            step_q         <= '0;
            cr_q           <= '0;
            ci_q           <= '0;
            max_ctr_q      <= '0;
            ctr_select_q   <= '0;
            x_q            <= '0;
            y_q            <= '0;
            out_cnt_q      <= '0;
            dispatch_ptr_q <= '0;
            out_ptr_q      <= '0;
        end else if (accept) begin
            running_q      <= 1'b1;
            disp_done_q    <= 1'b0;
            cr_start_q     <= cr_start;
            step_q         <= step;
            cr_q           <= cr_start;
            ci_q           <= ci_start;
            max_ctr_q      <= max_ctr;
            ctr_select_q   <= ctr_select;
            x_q            <= '0;
            y_q            <= '0;
            out_cnt_q      <= '0;
            dispatch_ptr_q <= '0;
            out_ptr_q      <= '0;
        end else begin
            if (dispatch) begin
                if (last_pixel) disp_done_q <= 1'b1;
                if (x_q == XW'(WIDTH - 1)) begin
                    x_q  <= '0;
                    y_q  <= y_q + 1'b1;
                    cr_q <= cr_start_q;
                    ci_q <= ci_q + step_q;
                end else begin
                    x_q  <= x_q + 1'b1;
                    cr_q <= cr_q + step_q;
                end
                dispatch_ptr_q <= (dispatch_ptr_q == PtrW'(LANES - 1)) ? '0
                                                                       : dispatch_ptr_q + 1'b1;
            end
            if (xfer) begin
                if (out_last) running_q <= 1'b0;
                out_cnt_q <= out_cnt_q + 1'b1;
                out_ptr_q <= (out_ptr_q == PtrW'(LANES - 1)) ? '0 : out_ptr_q + 1'b1;
            end
        end
    end

`ifdef MANDELBROT_JULIA_EN
    // Julia parameters are captured with the frame like the rest of the config.
    always_ff @(posedge clk) begin
        if (reset) begin
            julia_q <= 1'b0;
            jcr_q   <= '0;
            jci_q   <= '0;
        end else if (accept) begin
            julia_q <= julia;
            jcr_q   <= jcr;
            jci_q   <= jci;
        end
    end
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mandelbrot_lane #(
            .BITWIDTH (BITWIDTH),
            .CTRWIDTH (CTRWIDTH)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load    (lane_load[g]),
            .load_cr (ld_cr),
            .load_ci (ld_ci),
            .load_zr (ld_zr),
            .load_zi (ld_zi),
            .max_ctr (max_ctr_q),
            .free    (lane_free[g]),
            .state   (lane_state[g]),
            .ctr     (lane_ctr[g])
        );
    end

endmodule
